// File: rtl/verify_pkg.sv
// ============================================================================
// verify_pkg : shared widths, frame geometry and loader state encoding
// Revision   : 1.0
// ============================================================================
`default_nettype none

package verify_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_SIG_W  = 512;
  localparam int DEF_MSG_W  = 256;
  localparam int DEF_PK_W   = 256;

  function automatic int frame_words(input int sig_w, input int msg_w,
                                     input int pk_w, input int word_w);
    return (sig_w + msg_w + pk_w) / word_w;
  endfunction

  localparam int DEF_FRAME_WORDS = frame_words(DEF_SIG_W, DEF_MSG_W, DEF_PK_W, DEF_WORD_W);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    DRAIN  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } vr_state_e;

endpackage

`default_nettype wire

// File: rtl/vr_word_assembler.sv
// ============================================================================
// vr_word_assembler : word counter plus indexed write into the {pk,msg,sig} frame
// Revision          : 1.0
// ============================================================================
`default_nettype none

module vr_word_assembler #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 32,
  parameter int CNT_W   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic                        clr_i,
  input  logic [WORD_W-1:0]           data_i,
  output logic [N_WORDS*WORD_W-1:0]   frame_o,
  output logic [CNT_W-1:0]            cnt_o,
  output logic                        at_last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One register per word slot; only the slot matching the count is written.
  for (genvar k = 0; k < N_WORDS; k++) begin : g_word
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        word_q <= '0;
      end else if (wr_en_i && (cnt_q == CNT_W'(k))) begin
        word_q <= data_i;
      end
    end

    assign frame_o[k*WORD_W +: WORD_W] = word_q;
  end

  assign cnt_o     = cnt_q;
  assign at_last_o = (cnt_q == CNT_W'(N_WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/verify_req_loader.sv
// ============================================================================
// verify_req_loader : deserialises {sig,msg,pk} frames, launches the checker
//                     and returns a single-beat verdict / error response
// Revision          : 1.0
// ============================================================================
`default_nettype none

module verify_req_loader
  import verify_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int SIG_W       = DEF_SIG_W,
  parameter int MSG_W       = DEF_MSG_W,
  parameter int PK_W        = DEF_PK_W,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              cv_valid_o,
  output logic [SIG_W-1:0]  cv_sig_o,
  output logic [MSG_W-1:0]  cv_msg_o,
  output logic [PK_W-1:0]   cv_pk_o,
  input  logic              cv_ready_i,
  input  logic              cv_result_i,
  output logic              res_valid_o,
  output logic              res_result_o,
  output logic              res_error_o,
  input  logic              res_ready_i,
  output logic              busy_o
);

  localparam int N_WORDS = frame_words(SIG_W, MSG_W, PK_W, WORD_W);
  localparam int CNT_W   = $clog2(N_WORDS) + 1;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  vr_state_e                  state_q, state_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic                       seen_low_q, seen_low_d;
  logic                       res_result_q, res_result_d;
  logic                       res_error_q, res_error_d;

  logic                       wr_en;
  logic                       clr;
  logic                       accept;
  logic                       at_last;
  logic [CNT_W-1:0]           cnt;
  logic [N_WORDS*WORD_W-1:0]  frame;

  vr_word_assembler #(
    .WORD_W  (WORD_W),
    .N_WORDS (N_WORDS),
    .CNT_W   (CNT_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .clr_i     (clr),
    .data_i    (in_data_i),
    .frame_o   (frame),
    .cnt_o     (cnt),
    .at_last_o (at_last)
  );

  assign in_ready_o = !rst && ((state_q == LOAD) || (state_q == DRAIN));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d      = state_q;
    tmo_d        = '0;
    seen_low_d   = 1'b0;
    res_result_d = res_result_q;
    res_error_d  = res_error_q;
    wr_en        = 1'b0;
    clr          = 1'b0;
    cv_valid_o   = 1'b0;

    case (state_q)
      LOAD: begin
        wr_en = accept;
        if (accept) begin
          if (in_last_i && at_last) begin
            state_d = LAUNCH;
          end else if (in_last_i) begin
            state_d      = RESP;
            res_result_d = 1'b0;
            res_error_d  = 1'b1;
          end else if (at_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last_i) begin
          state_d      = RESP;
          res_result_d = 1'b0;
          res_error_d  = 1'b1;
        end
      end
      LAUNCH: begin
        if (cv_ready_i && !rst) begin
          cv_valid_o = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        tmo_d      = tmo_q + TMO_W'(1);
        // A verdict is only trusted after the checker has visibly gone busy.
        seen_low_d = seen_low_q | ~cv_ready_i;
        if (cv_ready_i && seen_low_q) begin
          state_d      = RESP;
          res_result_d = cv_result_i;
          res_error_d  = 1'b0;
        end else if ((TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST)) begin
          state_d      = RESP;
          res_result_d = 1'b0;
          res_error_d  = 1'b1;
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_d      = LOAD;
          clr          = 1'b1;
          res_result_d = 1'b0;
          res_error_d  = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      tmo_q        <= '0;
      seen_low_q   <= 1'b0;
      res_result_q <= 1'b0;
      res_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      seen_low_q   <= seen_low_d;
      res_result_q <= res_result_d;
      res_error_q  <= res_error_d;
    end
  end

  assign res_valid_o  = (state_q == RESP);
  assign res_result_o = res_result_q;
  assign res_error_o  = res_error_q;
  assign busy_o       = !((state_q == LOAD) && (cnt == '0));

  assign cv_sig_o = frame[0 +: SIG_W];
  assign cv_msg_o = frame[SIG_W +: MSG_W];
  assign cv_pk_o  = frame[SIG_W+MSG_W +: PK_W];

endmodule

`default_nettype wire

// File: tb/tb_verify_req_loader.sv
// ============================================================================
// tb_verify_req_loader : directed self-checking bench for verify_req_loader
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_verify_req_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         cv_valid;
  logic [511:0] cv_sig;
  logic [255:0] cv_msg;
  logic [255:0] cv_pk;
  logic         cv_ready;
  logic         cv_result;
  logic         res_valid;
  logic         res_result;
  logic         res_error;
  logic         res_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  verify_req_loader #(
    .WORD_W      (32),
    .SIG_W       (512),
    .MSG_W       (256),
    .PK_W        (256),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .cv_valid_o   (cv_valid),
    .cv_sig_o     (cv_sig),
    .cv_msg_o     (cv_msg),
    .cv_pk_o      (cv_pk),
    .cv_ready_i   (cv_ready),
    .cv_result_i  (cv_result),
    .res_valid_o  (res_valid),
    .res_result_o (res_result),
    .res_error_o  (res_error),
    .res_ready_i  (res_ready),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wd(input logic [7:0] seed, input int k);
    return {seed, 8'hC3, 8'(k), ~8'(k)};
  endfunction

  // Drives n words; in_last on word last_at; optional idle cycle between words.
  task automatic send_frame(input logic [7:0] seed, input int n, input int last_at, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
      in_valid = 1'b1;
      in_data  = wd(seed, i);
      in_last  = (i == last_at);
      #1;
      chk("in_ready_word", {31'd0, in_ready}, 32'd1);
      if (i == n - 1) chk("cv_valid_pre", {31'd0, cv_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  // Entered in the LAUNCH cycle with cv_ready high; checker busy for 3 cycles.
  task automatic run_check(input logic exp_res, input int hold);
    chk("cv_valid_launch", {31'd0, cv_valid}, 32'd1);
    chk("busy_launch", {31'd0, busy}, 32'd1);
    chk("in_ready_launch", {31'd0, in_ready}, 32'd0);
    tick();
    cv_ready = 1'b0;
    #1;
    chk("cv_valid_one_cycle", {31'd0, cv_valid}, 32'd0);
    repeat (3) tick();
    cv_ready  = 1'b1;
    cv_result = exp_res;
    #1;
    chk("res_valid_in_wait", {31'd0, res_valid}, 32'd0);
    tick();
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_result", {31'd0, res_result}, {31'd0, exp_res});
    chk("res_error", {31'd0, res_error}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      tick();
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_result", {31'd0, res_result}, {31'd0, exp_res});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    cv_result = 1'b0;
    #1;
    chk("res_valid_done", {31'd0, res_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic ack_error(input string tag);
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_res_error"}, {31'd0, res_error}, 32'd1);
    chk({tag, "_res_result"}, {31'd0, res_result}, 32'd0);
    chk({tag, "_cv_valid"}, {31'd0, cv_valid}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    chk({tag, "_res_valid_clr"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    cv_ready  = 1'b0;
    cv_result = 1'b0;
    res_ready = 1'b0;

    tick();
    tick();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    rst      = 1'b0;
    cv_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_cv_valid", {31'd0, cv_valid}, 32'd0);
    chk("post_rst_res_error", {31'd0, res_error}, 32'd0);
    chk("post_rst_sig", cv_sig[31:0], 32'd0);

    // 1: good frame, checker returns valid
    send_frame(8'h11, 32, 31, 1'b0);
    chk("t1_sig_w0", cv_sig[31:0], wd(8'h11, 0));
    chk("t1_sig_w15", cv_sig[511:480], wd(8'h11, 15));
    chk("t1_msg_w16", cv_msg[31:0], wd(8'h11, 16));
    chk("t1_pk_w31", cv_pk[255:224], wd(8'h11, 31));
    run_check(1'b1, 0);

    // 2: early in_last, then a good frame
    send_frame(8'h22, 11, 10, 1'b0);
    ack_error("t2");
    send_frame(8'h33, 32, 31, 1'b0);
    chk("t2_pk_w24", cv_pk[31:0], wd(8'h33, 24));
    run_check(1'b1, 0);

    // 3: missing in_last, trailing words drained
    send_frame(8'h44, 35, 34, 1'b0);
    chk("t3_sig_w0_kept", cv_sig[31:0], wd(8'h44, 0));
    chk("t3_pk_w31_kept", cv_pk[255:224], wd(8'h44, 31));
    ack_error("t3");

    // 4: sparse input, held response, invalid verdict
    send_frame(8'h55, 32, 31, 1'b1);
    chk("t4_pk_w31", cv_pk[255:224], wd(8'h55, 31));
    run_check(1'b0, 5);

    // 5: checker never returns
    send_frame(8'h66, 32, 31, 1'b0);
    chk("t5_cv_valid", {31'd0, cv_valid}, 32'd1);
    tick();
    cv_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("t5_no_resp_yet", {31'd0, res_valid}, 32'd0);
    end
    tick();
    ack_error("t5");
    cv_ready = 1'b1;

    // 6: reset mid-frame and mid-WAIT
    send_frame(8'h77, 21, 99, 1'b0);
    chk("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6a_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6a_busy", {31'd0, busy}, 32'd0);
    chk("t6a_sig", cv_sig[31:0], 32'd0);
    rst = 1'b0;
    #1;
    chk("t6a_in_ready_after", {31'd0, in_ready}, 32'd1);
    send_frame(8'h88, 32, 31, 1'b0);
    chk("t6b_cv_valid", {31'd0, cv_valid}, 32'd1);
    tick();
    cv_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6b_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t6b_busy", {31'd0, busy}, 32'd0);
    chk("t6b_cv_valid_rst", {31'd0, cv_valid}, 32'd0);
    chk("t6b_pk", cv_pk[255:224], 32'd0);
    rst      = 1'b0;
    cv_ready = 1'b1;
    #1;
    chk("t6b_in_ready_after", {31'd0, in_ready}, 32'd1);
    send_frame(8'h99, 32, 31, 1'b0);
    chk("t6c_sig_w0", cv_sig[31:0], wd(8'h99, 0));
    run_check(1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
